// File: rtl/serial_sub_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 8;

  function automatic int cntWidth(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_subtractor_fs_cell.sv
// Combinational 1-bit full subtractor: d = a - b - bin, with borrow-out.
module fs_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor, LSB first, one bit per clock with a borrow flip-flop.
// Optional signed-overflow output ovf is enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = cntWidth(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] aSh_q, aSh_d;
  logic [WIDTH-1:0] bSh_q, bSh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             br_q, br_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             dBit, brNext;
`ifdef SERIAL_SUB_OVF_EN
  logic             aMsb_q, aMsb_d;
  logic             bMsb_q, bMsb_d;
  logic             ovf_q, ovf_d;
`endif

  fs_cell uCell (
    .a    (aSh_q[0]),
    .b    (bSh_q[0]),
    .bin  (br_q),
    .d    (dBit),
    .bout (brNext)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      aSh_q   <= '0;
      bSh_q   <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      busy_q  <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      aMsb_q  <= 1'b0;
      bMsb_q  <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      aSh_q   <= aSh_d;
      bSh_q   <= bSh_d;
      res_q   <= res_d;
      br_q    <= br_d;
      busy_q  <= busy_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
      aMsb_q  <= aMsb_d;
      bMsb_q  <= bMsb_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  // DONE accepts a new start exactly like IDLE, giving WIDTH+1 cycle throughput.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    aSh_d   = aSh_q;
    bSh_d   = bSh_q;
    res_d   = res_q;
    br_d    = br_q;
    busy_d  = busy_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    aMsb_d  = aMsb_q;
    bMsb_d  = bMsb_q;
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
        if (start) begin
          aSh_d   = a;
          bSh_d   = b;
          br_d    = bin;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
`ifdef SERIAL_SUB_OVF_EN
          aMsb_d  = a[WIDTH-1];
          bMsb_d  = b[WIDTH-1];
`endif
        end
      end
      RUN: begin
        aSh_d = aSh_q >> 1;
        bSh_d = bSh_q >> 1;
        res_d = {dBit, res_q[WIDTH-1:1]};
        br_d  = brNext;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
          busy_d  = 1'b0;
          diff_d  = {dBit, res_q[WIDTH-1:1]};
          bout_d  = brNext;
`ifdef SERIAL_SUB_OVF_EN
          // dBit is the result MSB on the final bit.
          ovf_d   = (aMsb_q ^ bMsb_q) & (aMsb_q ^ dBit);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = busy_q;
  assign done = (state_q == DONE);
  assign diff = diff_q;
  assign bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=8); ovf checked when SERIAL_SUB_OVF_EN is defined.
module tb_serial_subtractor;

  typedef struct packed {
    logic [7:0] diff;
    logic       bout;
    logic       ovf;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       bin = 1'b0;
  logic       busy, done, bout;
  logic [7:0] diff;
`ifdef SERIAL_SUB_OVF_EN
  logic       ovf;
`endif

  exp_t expQ[$];
  int   testCount = 0;
  int   failCount = 0;
  int   doneCount = 0;
  int   pushCount = 0;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issues one start pulse; caller is positioned just after a rising edge.
  task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv, input logic binv,
                               input logic [7:0] ed, input logic eb, input logic eo, input bit push);
    exp_t e;
    a = av; b = bv; bin = binv; start = 1'b1;
    if (push) begin
      e.diff = ed; e.bout = eb; e.ovf = eo;
      expQ.push_back(e);
      pushCount++;
    end
    @(posedge clk); #1;
    start = 1'b0;
    a = 8'hCC; b = 8'h33; bin = 1'b1;
  endtask

  task automatic waitDone(output int cycles, output int busyCycles);
    bit found = 0;
    cycles = 0;
    busyCycles = (busy === 1'b1) ? 1 : 0;
    for (int i = 1; i <= 30 && !found; i++) begin
      @(posedge clk); #1;
      cycles = i;
      if (done === 1'b1) found = 1;
      else if (busy === 1'b1) busyCycles++;
    end
    if (!found) begin
      testCount++;
      failCount++;
      $display("[TB] FAIL done_timeout: got no done, expected done within 30 cycles");
    end
  endtask

  // Monitor: pops the scoreboard on every done pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        doneCount++;
        if (expQ.size() == 0) begin
          testCount++;
          failCount++;
          $display("[TB] FAIL unexpected_done: got done with diff 0x%0h, expected no done", diff);
        end else begin
          e = expQ.pop_front();
          checkOutput("diff", 32'(diff), 32'(e.diff));
          checkOutput("bout", 32'(bout), 32'(e.bout));
`ifdef SERIAL_SUB_OVF_EN
          checkOutput("ovf", 32'(ovf), 32'(e.ovf));
`endif
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before 200000 time units");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cyc, bcyc, first, second;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_diff", 32'(diff), 32'd0);
    checkOutput("rst_bout", 32'(bout), 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    applyStimulus(8'h55, 8'h23, 1'b0, 8'h32, 1'b0, 1'b0, 1);
    waitDone(cyc, bcyc);
    checkOutput("basic_latency", 32'(cyc), 32'd8);
    checkOutput("basic_busy_cycles", 32'(bcyc), 32'd8);
    checkOutput("busy_low_in_done", 32'(busy), 32'd0);

    applyStimulus(8'h10, 8'h20, 1'b0, 8'hF0, 1'b1, 1'b0, 1);
    waitDone(cyc, bcyc);
    applyStimulus(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1);
    waitDone(cyc, bcyc);
    applyStimulus(8'h55, 8'h23, 1'b1, 8'h31, 1'b0, 1'b0, 1);
    waitDone(cyc, bcyc);
    applyStimulus(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1);
    waitDone(cyc, bcyc);
    applyStimulus(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 1);
    waitDone(cyc, bcyc);

    // Collision: a start during RUN must be ignored.
    applyStimulus(8'h09, 8'h01, 1'b0, 8'h08, 1'b0, 1'b0, 1);
    repeat (3) begin @(posedge clk); #1; end
    a = 8'hFF; b = 8'h00; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("collision_busy", 32'(busy), 32'd1);
    checkOutput("diff_hold_in_run", 32'(diff), 32'h80);
    waitDone(cyc, bcyc);
    checkOutput("collision_latency", 32'(cyc), 32'd4);
    repeat (12) begin @(posedge clk); #1; end
    checkOutput("collision_done_count", 32'(doneCount), 32'(pushCount));

    // Back-to-back with start held high.
    expQ.push_back('{diff: 8'h7F, bout: 1'b0, ovf: 1'b1}); pushCount++;
    expQ.push_back('{diff: 8'hFF, bout: 1'b1, ovf: 1'b0}); pushCount++;
    a = 8'h80; b = 8'h01; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    a = 8'h01; b = 8'h02;
    first = 0; second = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (i == 9) begin
        start = 1'b0;
        checkOutput("b2b_reaccept_busy", 32'(busy), 32'd1);
      end
      if (done === 1'b1) begin
        if (first == 0) first = i;
        else if (second == 0) second = i;
      end
    end
    checkOutput("b2b_first_done", 32'(first), 32'd8);
    checkOutput("b2b_second_done", 32'(second), 32'd17);

    // Reset mid-operation aborts without a done pulse.
    applyStimulus(8'hAA, 8'h11, 1'b0, 8'h00, 1'b0, 1'b0, 0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_diff", 32'(diff), 32'd0);
    checkOutput("abort_bout", 32'(bout), 32'd0);
    @(negedge clk); rst = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    applyStimulus(8'h30, 8'h10, 1'b0, 8'h20, 1'b0, 1'b0, 1);
    waitDone(cyc, bcyc);
    checkOutput("post_reset_latency", 32'(cyc), 32'd8);
    applyStimulus(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1);
    waitDone(cyc, bcyc);

    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    checkOutput("scoreboard_empty", 32'(expQ.size()), 32'd0);
    checkOutput("total_done_count", 32'(doneCount), 32'(pushCount));
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
